flag_register: RTL and testbench



---
 rtl/flag_register_if.sv | 53 +++++
 rtl/flag_register.sv | 97 +++++++++
 tb/tb_flag_register.sv | 390 +++++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/flag_register_if.sv
// flag_register_if: ALU-side flag inputs, operation strobes and F/F' outputs of the Z80 flag register.
interface flag_register_if;
    logic [15:0] notResult;
    logic        notCY4;
    logic        notCY8;
    logic        CY12;
    logic        CY16;
    logic        notIsResultLow0;
    logic        is8bitOverflow;
    logic        is16bitOverflow;
    logic        notIs8bitEvenParity;
    logic        DAA_Flag_H;
    logic        notDAACY8;
    logic        notLow0;
    logic        notLow7;
    logic [7:0]  notDin;
    logic        PA_FLAG_ARITH8;
    logic        PA_FLAG_LOGIC;
    logic        PA_FLAG_ROTA;
    logic        PA_FLAG_SHIFT;
    logic        PA_FLAG_ADD16;
    logic        PA_FLAG_ADC16_LOW;
    logic        PA_FLAG_ADC16_HIGH;
    logic        PA_FLAG_DAA;
    logic        PA_FLAG_SCF;
    logic        PA_FLAG_CCF;
    logic        PA_FLAG_LOAD;
    logic        PA_FLAG_EXAF;
    logic        PA_FLAG_SUB;
    logic        PA_FLAG_LEFT;
    logic [7:0]  notF;
    logic        Flag_C;
    logic [7:0]  notFshadow;
    logic        adcPending;

    modport master (
        output notResult, notCY4, notCY8, CY12, CY16, notIsResultLow0, is8bitOverflow,
               is16bitOverflow, notIs8bitEvenParity, DAA_Flag_H, notDAACY8, notLow0, notLow7,
               notDin, PA_FLAG_ARITH8, PA_FLAG_LOGIC, PA_FLAG_ROTA, PA_FLAG_SHIFT, PA_FLAG_ADD16,
               PA_FLAG_ADC16_LOW, PA_FLAG_ADC16_HIGH, PA_FLAG_DAA, PA_FLAG_SCF, PA_FLAG_CCF,
               PA_FLAG_LOAD, PA_FLAG_EXAF, PA_FLAG_SUB, PA_FLAG_LEFT,
        input  notF, Flag_C, notFshadow, adcPending
    );

    modport slave (
        input  notResult, notCY4, notCY8, CY12, CY16, notIsResultLow0, is8bitOverflow,
               is16bitOverflow, notIs8bitEvenParity, DAA_Flag_H, notDAACY8, notLow0, notLow7,
               notDin, PA_FLAG_ARITH8, PA_FLAG_LOGIC, PA_FLAG_ROTA, PA_FLAG_SHIFT, PA_FLAG_ADD16,
               PA_FLAG_ADC16_LOW, PA_FLAG_ADC16_HIGH, PA_FLAG_DAA, PA_FLAG_SCF, PA_FLAG_CCF,
               PA_FLAG_LOAD, PA_FLAG_EXAF, PA_FLAG_SUB, PA_FLAG_LEFT,
        output notF, Flag_C, notFshadow, adcPending
    );
endinterface

// File: rtl/flag_register.sv
// flag_register: Z80 F register with two-pass ADC16/SBC16 flag sequencing.
// The F' shadow and EXAF swap exist only when FLAG_SHADOW_EN is defined.
module flag_register (
    input  logic            i_clock,
    input  logic            i_reset,
    flag_register_if.slave  bus
);
    typedef enum logic {IDLE, HIGH_PENDING} state_t;

    state_t      r_state, w_state_next;
    logic [7:0]  r_f, w_f_next;
    logic        r_zlow, w_zlow_next;
    logic [15:0] w_res;
    logic [7:0]  w_r, w_rh;
    logic        w_sub, w_z8, w_h8, w_c8, w_par, w_cshift;

    assign w_res    = ~bus.notResult;
    assign w_r      = w_res[7:0];
    assign w_rh     = w_res[15:8];
    assign w_sub    = bus.PA_FLAG_SUB;
    assign w_z8     = ~bus.notIsResultLow0;
    // Subtract: the ALU's raw carries are inverted borrows, so H/C flip polarity
    assign w_h8     = w_sub ? bus.notCY4 : ~bus.notCY4;
    assign w_c8     = w_sub ? bus.notCY8 : ~bus.notCY8;
    assign w_par    = ~bus.notIs8bitEvenParity;
    assign w_cshift = bus.PA_FLAG_LEFT ? ~bus.notLow7 : ~bus.notLow0;

`ifdef FLAG_SHADOW_EN
    logic [7:0] r_fs, w_fs_next;

    always_ff @(posedge i_clock)
        if (i_reset) r_fs <= 8'h00;
        else         r_fs <= w_fs_next;

    assign bus.notFshadow = ~r_fs;
`else
    assign bus.notFshadow = 8'hFF;
`endif

    always_comb begin
        w_f_next     = r_f;
        w_state_next = r_state;
        w_zlow_next  = r_zlow;
`ifdef FLAG_SHADOW_EN
        w_fs_next    = r_fs;
`endif
        if (bus.PA_FLAG_LOAD) begin
            w_f_next     = ~bus.notDin;
            w_state_next = IDLE;
        end else if (bus.PA_FLAG_EXAF) begin
`ifdef FLAG_SHADOW_EN
            w_f_next  = r_fs;
            w_fs_next = r_f;
`endif
            w_state_next = IDLE;
        end else if (bus.PA_FLAG_ADC16_HIGH && r_state == HIGH_PENDING) begin
            w_f_next     = {w_rh[7], r_zlow & (w_rh == 8'h00), w_rh[5], bus.CY12 ^ w_sub,
                            w_rh[3], bus.is16bitOverflow, w_sub, bus.CY16 ^ w_sub};
            w_state_next = IDLE;
        end else if (bus.PA_FLAG_ADC16_LOW) begin
            w_f_next     = {r_f[7:1], w_c8};
            w_zlow_next  = w_z8;
            w_state_next = HIGH_PENDING;
        end else if (bus.PA_FLAG_ARITH8)
            w_f_next = {w_r[7], w_z8, w_r[5], w_h8, w_r[3], bus.is8bitOverflow, w_sub, w_c8};
        else if (bus.PA_FLAG_LOGIC)
            w_f_next = {w_r[7], w_z8, w_r[5], 1'b1, w_r[3], w_par, 2'b00};
        else if (bus.PA_FLAG_ROTA)
            w_f_next = {r_f[7:6], w_r[5], 1'b0, w_r[3], r_f[2], 1'b0, w_cshift};
        else if (bus.PA_FLAG_SHIFT)
            w_f_next = {w_r[7], w_z8, w_r[5], 1'b0, w_r[3], w_par, 1'b0, w_cshift};
        else if (bus.PA_FLAG_ADD16)
            w_f_next = {r_f[7:6], w_res[13], bus.CY12 ^ w_sub, w_res[11], r_f[2], 1'b0, bus.CY16 ^ w_sub};
        else if (bus.PA_FLAG_DAA)
            w_f_next = {w_r[7], w_z8, w_r[5], bus.DAA_Flag_H, w_r[3], w_par, r_f[1], ~bus.notDAACY8};
        else if (bus.PA_FLAG_SCF)
            w_f_next = {r_f[7:5], 1'b0, r_f[3:2], 2'b01};
        else if (bus.PA_FLAG_CCF)
            w_f_next = {r_f[7:5], r_f[0], r_f[3:2], 1'b0, ~r_f[0]};
    end

    always_ff @(posedge i_clock) begin
        if (i_reset) begin
            r_state <= IDLE;
            r_f     <= 8'h00;
            r_zlow  <= 1'b0;
        end else begin
            r_state <= w_state_next;
            r_f     <= w_f_next;
            r_zlow  <= w_zlow_next;
        end
    end

    assign bus.notF       = ~r_f;
    assign bus.Flag_C     = r_f[0];
    assign bus.adcPending = (r_state == HIGH_PENDING);
endmodule

// File: tb/tb_flag_register.sv
// tb_flag_register: randomized checks of flag_register against an arithmetic-level flag model.
module tb_flag_register;
    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    flag_register_if u_if ();
    flag_register dut (.i_clock(clk), .i_reset(rst), .bus(u_if.slave));

    int ncmp = 0;
    int nfail = 0;
    logic [7:0] mf = 8'h00;
    logic [7:0] mfs = 8'h00;
    logic       mpend = 1'b0;

    function automatic logic [17:0] got();
        return {u_if.notF, u_if.Flag_C, u_if.notFshadow, u_if.adcPending};
    endfunction

    function automatic logic [17:0] expv();
        return {~mf, mf[0], ~mfs, mpend};
    endfunction

    task automatic clr_strobes();
        u_if.PA_FLAG_ARITH8 = 0; u_if.PA_FLAG_LOGIC = 0; u_if.PA_FLAG_ROTA = 0;
        u_if.PA_FLAG_SHIFT = 0; u_if.PA_FLAG_ADD16 = 0; u_if.PA_FLAG_ADC16_LOW = 0;
        u_if.PA_FLAG_ADC16_HIGH = 0; u_if.PA_FLAG_DAA = 0; u_if.PA_FLAG_SCF = 0;
        u_if.PA_FLAG_CCF = 0; u_if.PA_FLAG_LOAD = 0; u_if.PA_FLAG_EXAF = 0;
        u_if.PA_FLAG_SUB = 0; u_if.PA_FLAG_LEFT = 0;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        clr_strobes();
    endtask

    // Present a coherent ALU result: zero/parity derived from the low byte, raw carries as given
    task automatic drive_alu(input logic [15:0] res, input logic rc4, rc8, rc12, rc16, v8, v16);
        u_if.notResult = ~res;
        u_if.notCY4 = ~rc4;
        u_if.notCY8 = ~rc8;
        u_if.CY12 = rc12;
        u_if.CY16 = rc16;
        u_if.notIsResultLow0 = (res[7:0] != 8'h00);
        u_if.notIs8bitEvenParity = ^res[7:0];
        u_if.is8bitOverflow = v8;
        u_if.is16bitOverflow = v16;
    endtask

    task automatic load_f(input logic [7:0] f);
        u_if.notDin = ~f;
        u_if.PA_FLAG_LOAD = 1;
        tick();
        mf = f;
        mpend = 0;
    endtask

    task automatic do_arith8(input logic [7:0] a, b, input logic cin, sub);
        logic [7:0] bb, r;
        logic [8:0] raw;
        logic [4:0] raw4;
        logic ci, h, c, v;
        bb = sub ? ~b : b;
        ci = sub ? ~cin : cin;
        raw = {1'b0, a} + {1'b0, bb} + 9'(ci);
        raw4 = {1'b0, a[3:0]} + {1'b0, bb[3:0]} + 5'(ci);
        r = raw[7:0];
        if (sub) begin
            h = int'(a[3:0]) < int'(b[3:0]) + int'(cin);
            c = int'(a) < int'(b) + int'(cin);
            v = (a[7] != b[7]) && (r[7] != a[7]);
        end else begin
            h = int'(a[3:0]) + int'(b[3:0]) + int'(cin) > 15;
            c = int'(a) + int'(b) + int'(cin) > 255;
            v = (a[7] == b[7]) && (r[7] != a[7]);
        end
        drive_alu({8'($urandom), r}, raw4[4], raw[8], 1'($urandom), 1'($urandom), v, 1'($urandom));
        u_if.PA_FLAG_ARITH8 = 1;
        u_if.PA_FLAG_SUB = sub;
        mf = {r[7], r == 8'h00, r[5], h, r[3], v, sub, c};
    endtask

    task automatic test_reset();
        rst = 1;
        u_if.notDin = 8'h00;
        u_if.PA_FLAG_LOAD = 1;
        tick();
        rst = 0;
        mf = 8'h00; mfs = 8'h00; mpend = 0;
        ncmp++;
        if (got() !== expv()) begin nfail++; $display("FAIL reset got=%h exp=%h", got(), expv()); end
    endtask

    task automatic test_arith8();
        do_arith8(8'h7F, 8'h01, 1'b0, 1'b0);
        tick();
        ncmp++;
        if (u_if.notF !== 8'h6B) begin nfail++; $display("FAIL arith8_dir notF=%h exp=6b", u_if.notF); end
        for (int i = 0; i < 24; i++) begin
            do_arith8(8'($urandom), 8'($urandom), 1'($urandom), 1'($urandom));
            tick();
            ncmp++;
            if (got() !== expv()) begin nfail++; $display("FAIL arith8 got=%h exp=%h", got(), expv()); end
        end
    endtask

    task automatic test_logic();
        logic [7:0] r;
        load_f(8'hFF);
        drive_alu(16'h1200, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0);
        u_if.PA_FLAG_LOGIC = 1;
        tick();
        ncmp++;
        if (u_if.notF !== 8'hAB) begin nfail++; $display("FAIL logic_dir notF=%h exp=ab", u_if.notF); end
        for (int i = 0; i < 10; i++) begin
            r = 8'($urandom);
            drive_alu({8'($urandom), r}, 1'($urandom), 1'($urandom), 1'($urandom), 1'($urandom), 1'($urandom), 1'($urandom));
            u_if.PA_FLAG_LOGIC = 1;
            u_if.PA_FLAG_SUB = 1'($urandom);
            tick();
            mf = {r[7], r == 8'h00, r[5], 1'b1, r[3], ~^r, 2'b00};
            ncmp++;
            if (got() !== expv()) begin nfail++; $display("FAIL logic got=%h exp=%h", got(), expv()); end
        end
    endtask

    task automatic test_rot_shift();
        logic [7:0] v, r;
        logic left, shift, fill, co;
        load_f(8'($urandom));
        for (int i = 0; i < 16; i++) begin
            v = 8'($urandom); left = 1'($urandom); shift = 1'($urandom); fill = 1'($urandom);
            r = left ? {v[6:0], fill} : {fill, v[7:1]};
            co = left ? v[7] : v[0];
            drive_alu({8'($urandom), r}, 1'($urandom), 1'($urandom), 1'($urandom), 1'($urandom), 1'($urandom), 1'($urandom));
            u_if.notLow7 = ~v[7];
            u_if.notLow0 = ~v[0];
            u_if.PA_FLAG_LEFT = left;
            if (shift) u_if.PA_FLAG_SHIFT = 1; else u_if.PA_FLAG_ROTA = 1;
            tick();
            mf = shift ? {r[7], r == 8'h00, r[5], 1'b0, r[3], ~^r, 1'b0, co}
                       : {mf[7:6], r[5], 1'b0, r[3], mf[2], 1'b0, co};
            ncmp++;
            if (got() !== expv()) begin nfail++; $display("FAIL rot_shift got=%h exp=%h", got(), expv()); end
        end
    endtask

    task automatic test_add16();
        logic [15:0] a, b, bb, res;
        logic [16:0] raw;
        logic [12:0] raw12;
        logic sub, h, c;
        load_f(8'($urandom));
        for (int i = 0; i < 12; i++) begin
            a = 16'($urandom); b = 16'($urandom); sub = 1'($urandom);
            bb = sub ? ~b : b;
            raw = {1'b0, a} + {1'b0, bb} + 17'(sub);
            raw12 = {1'b0, a[11:0]} + {1'b0, bb[11:0]} + 13'(sub);
            res = raw[15:0];
            h = sub ? (a[11:0] < b[11:0]) : (int'(a[11:0]) + int'(b[11:0]) > 4095);
            c = sub ? (a < b) : (int'(a) + int'(b) > 65535);
            drive_alu(res, 1'($urandom), 1'($urandom), raw12[12], raw[16], 1'($urandom), 1'($urandom));
            u_if.PA_FLAG_ADD16 = 1;
            u_if.PA_FLAG_SUB = sub;
            tick();
            mf = {mf[7:6], res[13], h, res[11], mf[2], 1'b0, c};
            ncmp++;
            if (got() !== expv()) begin nfail++; $display("FAIL add16 got=%h exp=%h", got(), expv()); end
        end
    endtask

    task automatic test_daa();
        logic [7:0] r;
        logic dh, dc;
        for (int i = 0; i < 8; i++) begin
            load_f(8'($urandom));
            r = 8'($urandom); dh = 1'($urandom); dc = 1'($urandom);
            drive_alu({8'($urandom), r}, 1'($urandom), 1'($urandom), 1'($urandom), 1'($urandom), 1'($urandom), 1'($urandom));
            u_if.DAA_Flag_H = dh;
            u_if.notDAACY8 = ~dc;
            u_if.PA_FLAG_DAA = 1;
            u_if.PA_FLAG_SUB = 1'($urandom);
            tick();
            mf = {r[7], r == 8'h00, r[5], dh, r[3], ~^r, mf[1], dc};
            ncmp++;
            if (got() !== expv()) begin nfail++; $display("FAIL daa got=%h exp=%h", got(), expv()); end
        end
    endtask

    task automatic test_scf_ccf();
        logic scf;
        load_f(8'h00);
        u_if.PA_FLAG_SCF = 1;
        tick();
        ncmp++;
        if (u_if.notF !== 8'hFE || u_if.Flag_C !== 1'b1) begin nfail++; $display("FAIL scf notF=%h C=%b exp fe/1", u_if.notF, u_if.Flag_C); end
        u_if.PA_FLAG_CCF = 1;
        tick();
        ncmp++;
        if (u_if.notF !== 8'hEF || u_if.Flag_C !== 1'b0) begin nfail++; $display("FAIL ccf notF=%h C=%b exp ef/0", u_if.notF, u_if.Flag_C); end
        for (int i = 0; i < 8; i++) begin
            load_f(8'($urandom));
            scf = 1'($urandom);
            if (scf) u_if.PA_FLAG_SCF = 1; else u_if.PA_FLAG_CCF = 1;
            tick();
            mf = scf ? {mf[7:5], 1'b0, mf[3:2], 2'b01} : {mf[7:5], mf[0], mf[3:2], 1'b0, ~mf[0]};
            ncmp++;
            if (got() !== expv()) begin nfail++; $display("FAIL scf_ccf got=%h exp=%h", got(), expv()); end
        end
    endtask

    task automatic test_adc16();
        logic [15:0] a, b, bb, res;
        logic [16:0] raw;
        logic [12:0] raw12;
        logic [8:0]  raw8;
        logic [4:0]  raw4;
        logic sub, cin, ci, h, c, v;
        load_f(8'h01);
        for (int i = 0; i < 14; i++) begin
            if (i == 0) begin a = 16'h0000; b = 16'hFFFF; sub = 0; end
            else begin a = 16'($urandom); b = 16'($urandom); sub = 1'($urandom); end
            if (i > 0 && i % 4 == 0) b = a;
            cin = mf[0];
            bb = sub ? ~b : b;
            ci = sub ? ~cin : cin;
            raw = {1'b0, a} + {1'b0, bb} + 17'(ci);
            raw12 = {1'b0, a[11:0]} + {1'b0, bb[11:0]} + 13'(ci);
            raw8 = {1'b0, a[7:0]} + {1'b0, bb[7:0]} + 9'(ci);
            raw4 = {1'b0, a[3:0]} + {1'b0, bb[3:0]} + 5'(ci);
            res = raw[15:0];
            drive_alu(res, raw4[4], raw8[8], 1'($urandom), 1'($urandom), 1'($urandom), 1'($urandom));
            u_if.PA_FLAG_ADC16_LOW = 1;
            u_if.PA_FLAG_SUB = sub;
            tick();
            mf[0] = sub ? (int'(a[7:0]) < int'(b[7:0]) + int'(cin)) : (int'(a[7:0]) + int'(b[7:0]) + int'(cin) > 255);
            mpend = 1;
            ncmp++;
            if (got() !== expv()) begin nfail++; $display("FAIL adc16_low got=%h exp=%h", got(), expv()); end
            repeat ($urandom_range(0, 2)) tick();
            h = sub ? (int'(a[11:0]) < int'(b[11:0]) + int'(cin)) : (int'(a[11:0]) + int'(b[11:0]) + int'(cin) > 4095);
            c = sub ? (int'(a) < int'(b) + int'(cin)) : (int'(a) + int'(b) + int'(cin) > 65535);
            v = sub ? (a[15] != b[15] && res[15] != a[15]) : (a[15] == b[15] && res[15] != a[15]);
            drive_alu(res, 1'($urandom), 1'($urandom), raw12[12], raw[16], 1'($urandom), v);
            u_if.PA_FLAG_ADC16_HIGH = 1;
            u_if.PA_FLAG_SUB = sub;
            tick();
            mf = {res[15], res == 16'h0000, res[13], h, res[11], v, sub, c};
            mpend = 0;
            ncmp++;
            if (got() !== expv()) begin nfail++; $display("FAIL adc16_high got=%h exp=%h", got(), expv()); end
            if (i == 0) begin
                ncmp++;
                if (u_if.notF !== 8'hAE) begin nfail++; $display("FAIL adc16_dir notF=%h exp=ae", u_if.notF); end
            end
        end
    endtask

    task automatic test_load_exaf();
        load_f(8'hA5);
        ncmp++;
        if (got() !== expv()) begin nfail++; $display("FAIL load got=%h exp=%h", got(), expv()); end
        for (int i = 0; i < 2; i++) begin
            u_if.PA_FLAG_EXAF = 1;
            tick();
`ifdef FLAG_SHADOW_EN
            {mf, mfs} = {mfs, mf};
`endif
            ncmp++;
            if (got() !== expv()) begin nfail++; $display("FAIL exaf%0d got=%h exp=%h", i, got(), expv()); end
        end
        drive_alu(16'h0000, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        u_if.PA_FLAG_ADC16_LOW = 1;
        tick();
        mf[0] = 1; mpend = 1;
        u_if.PA_FLAG_EXAF = 1;
        tick();
`ifdef FLAG_SHADOW_EN
        {mf, mfs} = {mfs, mf};
`endif
        mpend = 0;
        ncmp++;
        if (got() !== expv()) begin nfail++; $display("FAIL exaf_pending got=%h exp=%h", got(), expv()); end
    endtask

    task automatic test_priority();
        logic [7:0] old;
        do_arith8(8'h7F, 8'h01, 1'b0, 1'b0);
        u_if.notDin = 8'h3C;
        u_if.PA_FLAG_LOAD = 1;
        tick();
        mf = 8'hC3;
        ncmp++;
        if (got() !== expv()) begin nfail++; $display("FAIL load_vs_arith got=%h exp=%h", got(), expv()); end
        do_arith8(8'($urandom), 8'($urandom), 1'($urandom), 1'($urandom));
        u_if.PA_FLAG_LOGIC = 1;
        u_if.PA_FLAG_SCF = 1;
        tick();
        ncmp++;
        if (got() !== expv()) begin nfail++; $display("FAIL arith_vs_logic got=%h exp=%h", got(), expv()); end
        old = mf;
        drive_alu(16'h55AA, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1);
        u_if.PA_FLAG_ADC16_HIGH = 1;
        tick();
        mf = old;
        ncmp++;
        if (got() !== expv()) begin nfail++; $display("FAIL high_in_idle got=%h exp=%h", got(), expv()); end
        do_arith8(8'h12, 8'h34, 1'b0, 1'b0);
        u_if.PA_FLAG_ADC16_LOW = 1;
        tick();
        mf = {old[7:1], 1'b0};
        mpend = 1;
        ncmp++;
        if (got() !== expv()) begin nfail++; $display("FAIL low_vs_arith got=%h exp=%h", got(), expv()); end
        drive_alu(16'h0001, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        u_if.PA_FLAG_ADC16_LOW = 1;
        tick();
        mf[0] = 1;
        drive_alu(16'h0000, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        u_if.PA_FLAG_ADC16_LOW = 1;
        tick();
        mf[0] = 0;
        ncmp++;
        if (got() !== expv()) begin nfail++; $display("FAIL low_restart got=%h exp=%h", got(), expv()); end
        drive_alu(16'h0000, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        u_if.PA_FLAG_ADC16_HIGH = 1;
        tick();
        mf = 8'h40; mpend = 0;
        ncmp++;
        if (got() !== expv()) begin nfail++; $display("FAIL restart_high got=%h exp=%h", got(), expv()); end
        drive_alu(16'h0100, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        u_if.PA_FLAG_ADC16_LOW = 1;
        tick();
        mf[0] = 1; mpend = 1;
        u_if.PA_FLAG_EXAF = 1;
        u_if.PA_FLAG_ADC16_HIGH = 1;
        tick();
`ifdef FLAG_SHADOW_EN
        {mf, mfs} = {mfs, mf};
`endif
        mpend = 0;
        ncmp++;
        if (got() !== expv()) begin nfail++; $display("FAIL exaf_vs_high got=%h exp=%h", got(), expv()); end
    endtask

    task automatic test_reset_mid_adc();
        drive_alu(16'h0000, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        u_if.PA_FLAG_ADC16_LOW = 1;
        tick();
        mf[0] = 1; mpend = 1;
        ncmp++;
        if (got() !== expv()) begin nfail++; $display("FAIL mid_low got=%h exp=%h", got(), expv()); end
        rst = 1;
        tick();
        rst = 0;
        mf = 8'h00; mfs = 8'h00; mpend = 0;
        ncmp++;
        if (got() !== expv()) begin nfail++; $display("FAIL mid_reset got=%h exp=%h", got(), expv()); end
        drive_alu(16'h0000, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1);
        u_if.PA_FLAG_ADC16_HIGH = 1;
        tick();
        ncmp++;
        if (got() !== expv()) begin nfail++; $display("FAIL mid_high got=%h exp=%h", got(), expv()); end
    endtask

    initial begin
        rst = 1;
        clr_strobes();
        drive_alu(16'h0000, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        u_if.DAA_Flag_H = 0;
        u_if.notDAACY8 = 1;
        u_if.notLow0 = 1;
        u_if.notLow7 = 1;
        u_if.notDin = 8'hFF;
        test_reset();
        test_arith8();
        test_logic();
        test_rot_shift();
        test_add16();
        test_daa();
        test_scf_ccf();
        test_adc16();
        test_load_exaf();
        test_priority();
        test_reset_mid_adc();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nfail);
        $finish;
    end
endmodule
